// File: rtl/vga_pkg.sv
// Shared VGA timing constants, palette and coordinate width for the video path.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Colour byte layout is [BLUE|GREEN|RED] = BBGGGRRR.
  localparam logic [7:0] COLOR_BLACK  = 8'h00;
  localparam logic [7:0] COLOR_WHITE  = 8'hFF;
  localparam logic [7:0] COLOR_GREEN  = 8'h38;
  localparam logic [7:0] COLOR_YELLOW = 8'h3F;
  localparam logic [7:0] COLOR_SPACE  = 8'h40;

  function automatic logic in_window(input logic [COORD_W-1:0] val,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clk pixel enable every CLK_DIV clks.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    pix_tick_o = (div_q == DIV_LAST);
    div_d      = pix_tick_o ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster counters plus a registered sync/colour stage; the outputs
// describe the pixel shown on xCoord/yCoord during the previous pixel period.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rgb_in,
  output logic [COORD_W-1:0] xCoord,
  output logic [COORD_W-1:0] yCoord,
  output logic               pix_tick,
  output logic               video_on,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [7:0]         rgb_out
);

  localparam int LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(LINE_LEN - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(FRAME_LINES - 1);
  localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

  logic               tick;
  logic               h_wrap;
  logic               v_wrap;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [7:0]         rgb_q, rgb_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .pix_tick_o(tick)
  );

  always_comb begin
    h_wrap   = (h_cnt_q == H_LAST);
    v_wrap   = (v_cnt_q == V_LAST);
    video_on = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;

    // Output stage samples the pre-increment coordinates, giving one pixel of latency.
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end
      hsync_d = ~in_window(h_cnt_q, HS_LO, HS_HI);
      vsync_d = ~in_window(v_cnt_q, VS_LO, VS_HI);
      rgb_d   = video_on ? rgb_in : COLOR_BLACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= COLOR_BLACK;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign xCoord      = h_cnt_q;
  assign yCoord      = v_cnt_q;
  assign pix_tick    = tick;
  assign frame_start = tick && h_wrap && v_wrap;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;

endmodule
